// File: rtl/sb_tx_serializer_pkt_if.sv
// ---------------------------------------------------------------------------
// sb_tx_serializer_pkt_if
//
// Packet handshake between the sideband packet framer (master) and the
// sideband TX serializer (slave).
//
// Signals:
//   i_valid  framer -> serializer  packet offered
//   o_ready  serializer -> framer  packet can be accepted this cycle
//   i_data   framer -> serializer  MAX_BEATS*DATA_W packet, beat 0 in the LSBs
//   i_len    framer -> serializer  number of beats minus one
// ---------------------------------------------------------------------------
interface sb_tx_serializer_pkt_if #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 2,
    parameter int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
);
    logic                          i_valid;
    logic                          o_ready;
    logic [MAX_BEATS*DATA_W-1:0]   i_data;
    logic [LEN_W-1:0]              i_len;

    modport master (output i_valid, i_data, i_len, input o_ready);
    modport slave  (input  i_valid, i_data, i_len, output o_ready);
endinterface

// File: rtl/sb_tx_serializer_pkt.sv
// ---------------------------------------------------------------------------
// sb_tx_serializer_pkt
//
// Serialises a 1..MAX_BEATS beat sideband packet MSB-first onto TXDATASB in
// the i_pll_clk domain, with no dead cycles between beats, followed by a
// mandatory run of GAP_UI low cycles. Dropping i_enable kills the packet.
//
// Ports:
//   i_pll_clk  serial bit clock, all logic on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_enable   lane enable; low forces idle / aborts a packet
//   pkt        packet handshake (slave side of sb_tx_serializer_pkt_if)
//   TXDATASB   registered serial data
//   o_busy     high while shifting or in the gap
//   o_done     one-cycle pulse on the last gap cycle of a completed packet
//   o_abort    one-cycle pulse when a shifting packet is killed by i_enable
//   o_txck_en  (only with SB_SER_TXCK_EN) registered, high during data bits
//
// Optional feature macro: SB_SER_TXCK_EN adds o_txck_en for TXCKSB gating.
// ---------------------------------------------------------------------------
module sb_tx_serializer_pkt #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 2,
    parameter int GAP_UI    = 32,
    parameter int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                         i_pll_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    sb_tx_serializer_pkt_if.slave        pkt,
    output logic                         TXDATASB,
    output logic                         o_busy,
    output logic                         o_done,
`ifdef SB_SER_TXCK_EN
    output logic                         o_txck_en,
`endif
    output logic                         o_abort
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t                      state_q, state_d;
    logic [DATA_W-1:0]           shift_q, shift_d;
    logic [MAX_BEATS*DATA_W-1:0] pkt_q;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [LEN_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
    logic                        txd_q, txd_d;
`ifdef SB_SER_TXCK_EN
    logic                        txck_q, txck_d;
`endif

    logic ready;
    logic done;
    logic abort;
    logic accept;
    logic last_bit;
    logic last_gap;

    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ready      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;

        last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));
        last_gap = (gap_cnt_q == GAP_W'(GAP_UI - 1));

        case (state_q)
            IDLE: begin
                ready = i_enable;
            end

            SHIFT: begin
                if (!i_enable) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    shift_d = '0;
                end else if (!last_bit) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end else if (beat_cnt_q < len_q) begin
                    // Next beat is loaded on the edge that retires the last
                    // bit of the current one, so beats abut with no dead UI.
                    shift_d    = pkt_q[(int'(beat_cnt_q) + 1) * DATA_W +: DATA_W];
                    bit_cnt_d  = '0;
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                end else begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end

            GAP: begin
                if (!i_enable) begin
                    // Quiet finish: no o_done, no o_abort.
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else if (last_gap) begin
                    done      = 1'b1;
                    ready     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides the IDLE / last-gap decisions above; ready is
        // already gated by i_enable, so accept and abort never coincide.
        accept = pkt.i_valid & ready & i_rst_n;
        if (accept) begin
            state_d    = SHIFT;
            shift_d    = pkt.i_data[DATA_W-1:0];
            bit_cnt_d  = '0;
            beat_cnt_d = '0;
            len_d      = (int'(pkt.i_len) >= MAX_BEATS) ? LEN_W'(MAX_BEATS - 1) : pkt.i_len;
        end

        // The output flop carries whatever bit the shift register will
        // present next, which aligns TXDATASB with the state register.
        txd_d  = (state_d == SHIFT) & shift_d[DATA_W-1];
`ifdef SB_SER_TXCK_EN
        txck_d = (state_d == SHIFT);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge i_pll_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            txd_q      <= 1'b0;
`ifdef SB_SER_TXCK_EN
            txck_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            txd_q      <= txd_d;
`ifdef SB_SER_TXCK_EN
            txck_q     <= txck_d;
`endif
        end
    end

    // NOTE: the packet store is only read after an accept has written it,
    // so it carries no reset and stays a plain data register bank.
    always_ff @(posedge i_pll_clk) begin
        if (accept) begin
            pkt_q <= pkt.i_data;
        end
    end

    assign TXDATASB    = txd_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done & i_rst_n;
    assign o_abort     = abort & i_rst_n;
    assign pkt.o_ready = ready & i_rst_n;
`ifdef SB_SER_TXCK_EN
    assign o_txck_en   = txck_q;
`endif

endmodule

// File: tb/tb_sb_tx_serializer_pkt.sv
// ---------------------------------------------------------------------------
// tb_sb_tx_serializer_pkt
//
// Self-checking bench. Main DUT uses the default geometry (64-bit beats,
// 2 beats, 32-UI gap); a second small DUT (8-bit beats, 3 beats, 4-UI gap)
// covers length clamping. Expected per-cycle outputs come from a packet-level
// model: each packet expands to its bits MSB-first per beat, then GAP_UI
// zeros with done/ready on the last one.
// Observation vector layout: {TXDATASB, o_busy, o_done, o_ready, o_abort, o_txck_en}
// ---------------------------------------------------------------------------
module tb_sb_tx_serializer_pkt;

    localparam int DW = 64;
    localparam int MB = 2;
    localparam int GP = 32;
    localparam int C_DW = 8;
    localparam int C_MB = 3;
    localparam int C_GP = 4;

    logic clk;
    logic rst_n;
    logic enable;
    logic c_enable;
    logic txd, busy, done, abort, txck_obs;
    logic c_txd, c_busy, c_done, c_abort, c_txck_obs;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    sb_tx_serializer_pkt_if #(.DATA_W(DW), .MAX_BEATS(MB), .LEN_W(1)) m_if ();
    sb_tx_serializer_pkt_if #(.DATA_W(C_DW), .MAX_BEATS(C_MB), .LEN_W(2)) c_if ();

`ifdef SB_SER_TXCK_EN
    localparam bit HAS_CK = 1'b1;
`else
    localparam bit HAS_CK = 1'b0;
    assign txck_obs   = 1'b0;
    assign c_txck_obs = 1'b0;
`endif

    sb_tx_serializer_pkt #(.DATA_W(DW), .MAX_BEATS(MB), .GAP_UI(GP), .LEN_W(1)) dut (
        .i_pll_clk (clk),
        .i_rst_n   (rst_n),
        .i_enable  (enable),
        .pkt       (m_if),
        .TXDATASB  (txd),
        .o_busy    (busy),
        .o_done    (done),
`ifdef SB_SER_TXCK_EN
        .o_txck_en (txck_obs),
`endif
        .o_abort   (abort)
    );

    sb_tx_serializer_pkt #(.DATA_W(C_DW), .MAX_BEATS(C_MB), .GAP_UI(C_GP), .LEN_W(2)) dut_c (
        .i_pll_clk (clk),
        .i_rst_n   (rst_n),
        .i_enable  (c_enable),
        .pkt       (c_if),
        .TXDATASB  (c_txd),
        .o_busy    (c_busy),
        .o_done    (c_done),
`ifdef SB_SER_TXCK_EN
        .o_txck_en (c_txck_obs),
`endif
        .o_abort   (c_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] obs_m();
        return {txd, busy, done, m_if.o_ready, abort, txck_obs};
    endfunction

    function automatic logic [5:0] obs_c();
        return {c_txd, c_busy, c_done, c_if.o_ready, c_abort, c_txck_obs};
    endfunction

    // Packet-level reference: bits of each beat MSB-first, then the gap.
    task automatic model_pkt(input logic [127:0] data, input int len, input int dw,
                             input int maxb, input int gap);
        int eff;
        eff = (len >= maxb) ? maxb - 1 : len;
        for (int b = 0; b <= eff; b++)
            for (int k = dw - 1; k >= 0; k--)
                exp_q.push_back({data[b*dw+k], 1'b1, 1'b0, 1'b0, 1'b0, HAS_CK});
        for (int g = 0; g < gap; g++)
            exp_q.push_back({1'b0, 1'b1, (g == gap - 1), (g == gap - 1), 1'b0, 1'b0});
    endtask

    // Offers a packet to the main DUT; returns just after the accepting edge
    // with i_valid still high. ok=0 if o_ready never appeared.
    task automatic offer(input logic [127:0] data, input int len, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        m_if.i_data  = data;
        m_if.i_len   = len[0];
        m_if.i_valid = 1'b1;
        for (int t = 0; t < 400 && !ok; t++) begin
            #1;
            if (m_if.o_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic [5:0] o;
        rst_n = 1'b0;
        enable = 1'b1;
        c_enable = 1'b1;
        m_if.i_valid = 1'b1;
        m_if.i_data = '0;
        m_if.i_len = '0;
        c_if.i_valid = 1'b0;
        c_if.i_data = '0;
        c_if.i_len = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = obs_m();
            checks++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL reset_main cyc %0d got %b exp %b", i, o, 6'b0);
            end
            o = obs_c();
            checks++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL reset_clamp cyc %0d got %b exp %b", i, o, 6'b0);
            end
        end
        m_if.i_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        o = obs_m();
        checks++;
        if (o !== 6'b000100) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", o, 6'b000100);
        end
    endtask

    task automatic test_single_beat();
        logic [127:0] d;
        logic [5:0] o, e;
        bit ok;
        int n;
        d = {64'h0, 64'hA5A5_0000_FFFF_1234};
        offer(d, 0, ok);
        m_if.i_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept got 0 exp 1"); end
        model_pkt(d, 0, DW, MB, GP);
        n = exp_q.size();
        for (int i = 0; i < n && ok; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_m();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single cyc %0d got %b exp %b", i, o, e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_two_beats();
        logic [127:0] pk[2];
        logic [5:0] o, e;
        bit ok;
        int n;
        pk[0] = {64'h8000_0000_0000_0000, 64'h1};
        pk[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        for (int p = 0; p < 2; p++) begin
            offer(pk[p], 1, ok);
            m_if.i_valid = 1'b0;
            checks++;
            if (!ok) begin errors++; $display("FAIL two_beat_accept pkt %0d got 0 exp 1", p); end
            model_pkt(pk[p], 1, DW, MB, GP);
            n = exp_q.size();
            for (int i = 0; i < n && ok; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_m();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL two_beat pkt %0d cyc %0d got %b exp %b", p, i, o, e);
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        logic [5:0] o, e;
        bit ok;
        int n;
        a = {64'h0, rand128() | 128'h1};
        b = {64'h0, rand128() | 128'h8000_0000_0000_0000};
        b[127:64] = 64'h0;
        offer(a, 0, ok);
        m_if.i_data = b;
        m_if.i_len = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_accept got 0 exp 1"); end
        model_pkt(a, 0, DW, MB, GP);
        model_pkt(b, 0, DW, MB, GP);
        n = exp_q.size();
        for (int i = 0; i < n && ok; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_m();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b cyc %0d got %b exp %b", i, o, e);
            end
            if (i == DW + GP - 1) begin
                @(posedge clk);
                #1;
                m_if.i_valid = 1'b0;
            end
        end
        m_if.i_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [5:0] o, e;
        bit ok;
        int len, n;
        for (int p = 0; p < 6; p++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = rand128();
            len = $urandom_range(0, 1);
            offer(d, len, ok);
            m_if.i_valid = 1'b0;
            checks++;
            if (!ok) begin errors++; $display("FAIL random_accept pkt %0d got 0 exp 1", p); end
            model_pkt(d, len, DW, MB, GP);
            n = exp_q.size();
            for (int i = 0; i < n && ok; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_m();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random pkt %0d len %0d cyc %0d got %b exp %b", p, len, i, o, e);
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_abort();
        logic [127:0] d;
        logic [5:0] o, e;
        bit ok;
        int n;
        d = rand128();
        offer(d, 1, ok);
        m_if.i_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_accept got 0 exp 1"); end
        model_pkt(d, 1, DW, MB, GP);
        for (int i = 0; i < 20 && ok; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_m();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_pre cyc %0d got %b exp %b", i, o, e);
            end
        end
        exp_q.delete();
        @(negedge clk);
        enable = 1'b0;
        #1;
        e = {d[DW-1-20], 1'b1, 1'b0, 1'b0, 1'b1, HAS_CK};
        o = obs_m();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_pulse got %b exp %b", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = obs_m();
            checks++;
            if (o !== 6'b0) begin
                errors++;
                $display("FAIL abort_idle cyc %0d got %b exp %b", i, o, 6'b0);
            end
        end
        enable = 1'b1;
        #1;
        o = obs_m();
        checks++;
        if (o !== 6'b000100) begin
            errors++;
            $display("FAIL abort_reenable got %b exp %b", o, 6'b000100);
        end
        d = rand128();
        offer(d, 1, ok);
        m_if.i_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_fresh_accept got 0 exp 1"); end
        model_pkt(d, 1, DW, MB, GP);
        n = exp_q.size();
        for (int i = 0; i < n && ok; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_m();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_fresh cyc %0d got %b exp %b", i, o, e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        logic [127:0] d;
        logic [5:0] o, e;
        bit ok;
        d = rand128();
        offer(d, 1, ok);
        m_if.i_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_accept got 0 exp 1"); end
        model_pkt(d, 1, DW, MB, GP);
        for (int i = 0; i < 40 && ok; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_m();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_pre cyc %0d got %b exp %b", i, o, e);
            end
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        e = {d[DW-1-40], 1'b1, 1'b0, 1'b0, 1'b0, HAS_CK};
        o = obs_m();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rstmid_assert got %b exp %b", o, e);
        end
        @(negedge clk);
        o = obs_m();
        checks++;
        if (o !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_cleared got %b exp %b", o, 6'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            o = obs_m();
            checks++;
            if (o !== 6'b000100) begin
                errors++;
                $display("FAIL rstmid_quiet cyc %0d got %b exp %b", i, o, 6'b000100);
            end
        end
    endtask

    task automatic test_clamp();
        int lens[3] = '{3, 2, 0};
        logic [127:0] d;
        logic [5:0] o, e;
        bit ok;
        int n;
        for (int p = 0; p < 3; p++) begin
            d = '0;
            d[C_MB*C_DW-1:0] = 24'($urandom);
            @(negedge clk);
            c_if.i_data  = d[C_MB*C_DW-1:0];
            c_if.i_len   = 2'(lens[p]);
            c_if.i_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                #1;
                if (c_if.o_ready === 1'b1) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            c_if.i_valid = 1'b0;
            checks++;
            if (!ok) begin errors++; $display("FAIL clamp_accept len %0d got 0 exp 1", lens[p]); end
            model_pkt(d, lens[p], C_DW, C_MB, C_GP);
            n = exp_q.size();
            for (int i = 0; i < n && ok; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_c();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL clamp len %0d cyc %0d got %b exp %b", lens[p], i, o, e);
                end
            end
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beats();
        test_back_to_back();
        test_random();
        test_abort();
        test_reset_mid_packet();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_tx_serializer_pkt.md
Name: sb_tx_serializer_pkt

Overview:
- Parametrised, handshake-driven successor to the sideband TX serializer. Runs in the single i_pll_clk domain (800 MHz class).
- Accepts a sideband packet of 1..MAX_BEATS beats of DATA_W bits over a valid/ready interface. Beats are typically header plus optional data.
- Serialises the packet MSB-first onto TXDATASB with no dead cycles between beats, then drives a mandatory low gap of GAP_UI cycles.
- Sits between the sideband packet framer and the sideband analog TX pad model. Supports mid-packet abort via lane enable.

Parameters:
- DATA_W, 64, bits per beat; must be >= 2.
- MAX_BEATS, 2, max beats per packet (2 = 64-bit header + 64-bit data); must be >= 1.
- GAP_UI, 32, low UI cycles inserted after every packet; must be >= 1.
- LEN_W, (MAX_BEATS>1 ? $clog2(MAX_BEATS) : 1), width of i_len.

Ports:
- i_pll_clk, in, 1, serial bit clock; all logic on rising edge.
- i_rst_n, in, 1, synchronous active-low reset.
- i_enable, in, 1, lane enable; low forces idle/abort.
- i_valid, in, 1, packet offered.
- o_ready, out, 1, block can accept a packet this cycle.
- i_data, in, MAX_BEATS*DATA_W, packet; beat 0 = bits [DATA_W-1:0], beat k = bits [(k+1)*DATA_W-1 : k*DATA_W].
- i_len, in, LEN_W, number of beats minus 1; sampled at accept.
- TXDATASB, out, 1, serial data.
- o_busy, out, 1, high in SHIFT or GAP.
- o_done, out, 1, one-cycle pulse on the last GAP cycle of a completed packet.
- o_abort, out, 1, one-cycle pulse when a packet is killed by i_enable low.

Behaviour:
- Reset (i_rst_n low at a clock edge) puts every output in its reset state:
  - state = IDLE
  - TXDATASB = 0, o_busy = 0, o_done = 0, o_abort = 0
  - o_ready = 0 during reset, then follows its rule below
  - counters and the shift register are cleared
- Reset mid-packet discards the packet silently; o_abort is not pulsed.
- FSM states are IDLE, SHIFT and GAP.
- IDLE:
  - o_ready = i_enable.
  - Accept = i_valid & o_ready.
  - On accept, latch i_data and i_len; i_len >= MAX_BEATS clamps to MAX_BEATS-1.
  - On accept, load beat 0 into the shift register, set beat_cnt = 0 and bit_cnt = 0, and go to SHIFT.
- Latency: accept at edge N; TXDATASB carries beat0[DATA_W-1] during cycle N+1.
- SHIFT:
  - TXDATASB = shift_reg[DATA_W-1] (registered output); shift left by 1 each cycle; bit_cnt increments.
  - When bit_cnt == DATA_W-1 and beat_cnt < len: load the next beat on the same edge. No gap between beats; beat_cnt increments.
  - When bit_cnt == DATA_W-1 and beat_cnt == len: go to GAP with gap_cnt = 0.
- GAP:
  - TXDATASB = 0; gap_cnt increments.
  - The last gap cycle is gap_cnt == GAP_UI-1. In that cycle o_done = 1 and o_ready = i_enable.
  - Accept in the last gap cycle goes directly to SHIFT, giving back-to-back packets separated by exactly GAP_UI zeros.
  - With no accept, return to IDLE.
- Timing: total cycles per packet = (len+1)*DATA_W + GAP_UI.
- o_busy is 1 in SHIFT and GAP and 0 in IDLE.
- i_enable low (abort):
  - If i_enable is low in SHIFT or GAP, the next state is IDLE and TXDATASB = 0 from the next cycle.
  - o_abort pulses 1 cycle, in SHIFT only; dropping i_enable in GAP is a clean finish with no o_abort and no o_done.
  - o_ready stays 0 while i_enable is low.
- Simultaneous accept and abort cannot occur, because o_ready is gated by i_enable.
- i_data and i_len are don't-care outside the accept cycle.
- Counters wrap only by explicit reset to 0; no free-running counter.

Optional Feature:
- Macro: SB_SER_TXCK_EN.
- When defined, adds output o_txck_en (1 bit):
  - Registered, cycle-aligned with TXDATASB.
  - High exactly during SHIFT data bits; low in GAP, IDLE and after abort.
  - Reset value 0.
  - Used by the pad model to gate the forwarded TXCKSB.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single beat: DATA_W=64, i_len=0, i_data[63:0]=64'hA5A5_0000_FFFF_1234, accept at cycle 10 -> TXDATASB reproduces bits 63..0 in cycles 11..74; 0 in cycles 75..106; o_done=1 at cycle 106; o_busy cycles 11..106.
- Two beats: i_len=1, beat0=64'h1, beat1=64'h8000_0000_0000_0000 -> TXDATASB=1 at cycle N+64 and N+65, 0 in all other SHIFT cycles; gap of 32 zeros; no dead cycle between beats.
- Back-to-back: i_valid held high with two 1-beat packets -> second accepted on the first packet's o_done cycle; exactly 32 zeros between last bit of packet 1 and first bit of packet 2.
- Abort: drop i_enable at bit 20 of a packet -> o_abort=1 for one cycle; TXDATASB=0, o_busy=0, o_ready=0 next cycle; re-raise i_enable -> o_ready=1 and a fresh packet serialises correctly.
- Reset mid-packet: assert i_rst_n=0 for 1 cycle at bit 40 -> next cycle all outputs 0 and state IDLE; no o_abort, no o_done.
- Clamp and macro: MAX_BEATS=2, i_len=1 with 64'h0/64'hFFFF... -> 64 zeros then 64 ones; with SB_SER_TXCK_EN, o_txck_en high for exactly 128 cycles aligned with the data.
